// File: rtl/sdr_rd_pkg.sv
// Shared SDRAM timing, command encodings and helpers for the read-path controller.
// The write controller uses the same timings and command set.
package sdr_rd_pkg;

  localparam int TCK_PS  = 6000;
  localparam int TRCD_PS = 18000;
  localparam int TRP_PS  = 18000;

  typedef enum logic [2:0] {
    CMD_PRECHARGE = 3'b010,
    CMD_ACTIVE    = 3'b011,
    CMD_WRITE     = 3'b100,
    CMD_READ      = 3'b101,
    CMD_NOP       = 3'b111
  } sdr_cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ACTIVE    = 4'd1,
    ST_READ      = 4'd2,
    ST_BURST     = 4'd3,
    ST_PRECHARGE = 4'd4
  } rd_state_e;

  // Round a picosecond timing up to whole controller clocks.
  function automatic int ps_to_clk(input int ps);
    return (ps + TCK_PS - 1) / TCK_PS;
  endfunction

  // READ address: A12..A11 = 0, A10 = 0 (no auto-precharge), A9 = 0, column.
  function automatic logic [12:0] read_addr(input logic [8:0] col);
    return {2'b00, 1'b0, 1'b0, col};
  endfunction

endpackage

// File: rtl/sdr_rd_capture.sv
// Read-data capture for sdr_rd: a CL-deep valid-tag pipeline that lines up with
// the CAS latency, then registers sdr_DQ into rd_data when a tag emerges.
module sdr_rd_capture
  import sdr_rd_pkg::*;
#(
  parameter int CL = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tag_in,
  input  logic [15:0] sdr_dq,
  output logic [15:0] rd_data,
  output logic        rd_data_vld
);

  logic [CL-1:0] pipe_r;
  logic [15:0]   data_r;
  logic          vld_r;

  // Shift tags through the CAS-latency pipeline and sample DQ on emergence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_r <= '0;
      data_r <= 16'h0000;
      vld_r  <= 1'b0;
    end else begin
      pipe_r[0] <= tag_in;
      for (int i = 1; i < CL; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
      vld_r <= pipe_r[CL-1];
      if (pipe_r[CL-1]) begin
        data_r <= sdr_dq;
      end
    end
  end

  assign rd_data     = data_r;
  assign rd_data_vld = vld_r;

endmodule

// File: rtl/sdr_rd.sv
// SDRAM single-burst read controller: ACTIVE, READ, wait CAS latency, capture a
// fixed burst, PRECHARGE, then pulse rd_exit. Commands appear one clock after the state.
module sdr_rd
  import sdr_rd_pkg::*;
#(
  parameter int NRCD = ps_to_clk(TRCD_PS),
  parameter int NRP  = ps_to_clk(TRP_PS),
  parameter int CL   = 3,
  parameter int BL   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdr_rd_req,
  input  logic [1:0]  sdr_bank_addr,
  input  logic [12:0] sdr_row_addr,
  input  logic [8:0]  sdr_col_addr,
  output logic        sdr_CKE,
  output logic        sdr_nCS,
  output logic [1:0]  sdr_BA,
  output logic [12:0] sdr_A,
  output logic        sdr_nRAS,
  output logic        sdr_nCAS,
  output logic        sdr_nWE,
  output logic [1:0]  sdr_DQM,
  input  logic [15:0] sdr_DQ,
  output logic [15:0] rd_data,
  output logic        rd_data_vld,
  output logic        rd_busy,
  output logic        rd_exit
);

  rd_state_e   state_r;
  logic [3:0]  cnt_r;
  sdr_cmd_e    cmd_r;
  logic [12:0] a_r;
  logic [12:0] row_r;
  logic [8:0]  col_r;
  logic [1:0]  ba_r;
  logic        busy_r;
  logic        exit_r;
  logic        tag_r;

  // Main FSM; command, address, busy, exit and capture tag are registered from the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      cmd_r   <= CMD_NOP;
      a_r     <= 13'd0;
      row_r   <= 13'd0;
      col_r   <= 9'd0;
      ba_r    <= 2'd0;
      busy_r  <= 1'b0;
      exit_r  <= 1'b0;
      tag_r   <= 1'b0;
    end else begin
      cmd_r  <= CMD_NOP;
      exit_r <= 1'b0;
      tag_r  <= 1'b0;
      busy_r <= (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (sdr_rd_req) begin
            state_r <= ST_ACTIVE;
            cnt_r   <= 4'd0;
            row_r   <= sdr_row_addr;
            col_r   <= sdr_col_addr;
            ba_r    <= sdr_bank_addr;
          end
        end
        ST_ACTIVE: begin
          if (cnt_r == 4'd0) begin
            cmd_r <= CMD_ACTIVE;
            a_r   <= row_r;
          end
          if (cnt_r == 4'(NRCD - 1)) begin
            state_r <= ST_READ;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_READ: begin
          cmd_r   <= CMD_READ;
          a_r     <= read_addr(col_r);
          tag_r   <= 1'b1;
          state_r <= ST_BURST;
          cnt_r   <= 4'd0;
        end
        // Tags cover BL cycles from the READ command; leave once the last word is on DQ.
        ST_BURST: begin
          tag_r <= (cnt_r < 4'(BL - 1));
          if (cnt_r == 4'(CL + BL - 2)) begin
            state_r <= ST_PRECHARGE;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_PRECHARGE: begin
          if (cnt_r == 4'd0) begin
            cmd_r <= CMD_PRECHARGE;
            a_r   <= 13'd0;
          end
          if (cnt_r == 4'(NRP)) begin
            exit_r  <= 1'b1;
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  sdr_rd_capture #(
    .CL (CL)
  ) u_capture (
    .clk         (clk),
    .rst_n       (rst_n),
    .tag_in      (tag_r),
    .sdr_dq      (sdr_DQ),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld)
  );

  assign sdr_CKE = 1'b1;
  assign sdr_nCS = 1'b0;
  assign sdr_DQM = 2'b00;
  assign sdr_BA  = ba_r;
  assign sdr_A   = a_r;
  assign {sdr_nRAS, sdr_nCAS, sdr_nWE} = cmd_r;
  assign rd_busy = busy_r;
  assign rd_exit = exit_r;

endmodule

// File: tb/tb_sdr_rd.sv
// Directed bench for sdr_rd: default build plus a CL=2/BL=8 build, cycle-exact
// command, address, data, busy and exit checks against hand-derived schedules.
module tb_sdr_rd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req2;
  logic [1:0]  bank;
  logic [12:0] row;
  logic [8:0]  col;
  logic [15:0] dq;

  logic        cke, ncs, nras, ncas, nwe, vld, busy, ext;
  logic [1:0]  ba, dqm;
  logic [12:0] a;
  logic [15:0] data;

  logic        cke2, ncs2, nras2, ncas2, nwe2, vld2, busy2, ext2;
  logic [1:0]  ba2, dqm2;
  logic [12:0] a2;
  logic [15:0] data2;

  int n_tests = 0;
  int n_fail  = 0;
  int r;
  logic [15:0] wa [4];
  logic [15:0] wb [4];

  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] ACT = 3'b011;
  localparam logic [2:0] RD  = 3'b101;
  localparam logic [2:0] PRE = 3'b010;

  always #5 clk = ~clk;

  sdr_rd dut (
    .clk(clk), .rst_n(rst_n), .sdr_rd_req(req), .sdr_bank_addr(bank),
    .sdr_row_addr(row), .sdr_col_addr(col), .sdr_CKE(cke), .sdr_nCS(ncs),
    .sdr_BA(ba), .sdr_A(a), .sdr_nRAS(nras), .sdr_nCAS(ncas), .sdr_nWE(nwe),
    .sdr_DQM(dqm), .sdr_DQ(dq), .rd_data(data), .rd_data_vld(vld),
    .rd_busy(busy), .rd_exit(ext)
  );

  sdr_rd #(.CL(2), .BL(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .sdr_rd_req(req2), .sdr_bank_addr(bank),
    .sdr_row_addr(row), .sdr_col_addr(col), .sdr_CKE(cke2), .sdr_nCS(ncs2),
    .sdr_BA(ba2), .sdr_A(a2), .sdr_nRAS(nras2), .sdr_nCAS(ncas2), .sdr_nWE(nwe2),
    .sdr_DQM(dqm2), .sdr_DQ(dq), .rd_data(data2), .rd_data_vld(vld2),
    .rd_busy(busy2), .rd_exit(ext2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_cmd(input int rr, input int rd_c, input int pre_c);
    if (rr == 1) return ACT;
    if (rr == rd_c) return RD;
    if (rr == pre_c) return PRE;
    return NOP;
  endfunction

  // One default-build transaction from acceptance through one cycle past rd_exit.
  task automatic txn_default(input logic [1:0] b, input logic [12:0] rw, input logic [8:0] cl,
                             input logic [15:0] base);
    bank = b; row = rw; col = cl; req = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 0) req = 1'b0;
      check($sformatf("t3 cmd c%0d", c), 16'({nras, ncas, nwe}), 16'(exp_cmd(c, 4, 11)));
      check($sformatf("t3 busy c%0d", c), 16'(busy), 16'(c >= 1 && c <= 14));
      check($sformatf("t3 exit c%0d", c), 16'(ext), 16'(c == 14));
      check($sformatf("t3 vld c%0d", c), 16'(vld), 16'(c >= 8 && c <= 11));
      if (c == 1) check("t3 act A", 16'(a), 16'(rw));
      if (c == 4) check("t3 rd A", 16'(a), 16'(cl));
      if (c >= 8 && c <= 11) check($sformatf("t3 data c%0d", c), data, base + 16'(c - 8));
      dq = (c >= 7 && c <= 10) ? base + 16'(c - 7) : 16'hDEAD;
    end
  endtask

  initial begin
    wa[0] = 16'h1111; wa[1] = 16'h2222; wa[2] = 16'h3333; wa[3] = 16'h4444;
    wb[0] = 16'hA001; wb[1] = 16'hB002; wb[2] = 16'hC003; wb[3] = 16'hD004;
    rst_n = 1'b0; req = 1'b0; req2 = 1'b0;
    bank = 2'd0; row = 13'd0; col = 9'd0; dq = 16'hDEAD;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst cmd", 16'({nras, ncas, nwe}), 16'(NOP));
    check("rst A", 16'(a), 16'h0000);
    check("rst BA", 16'(ba), 16'h0000);
    check("rst data", data, 16'h0000);
    check("rst vld/busy/exit", 16'({vld, busy, ext}), 16'h0000);
    check("rst pins", 16'({cke, ncs, dqm}), 16'h0008);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read, ignored requests at edges 6 and 14, back-to-back acceptance at edge 15
    bank = 2'd2; row = 13'h0ABC; col = 9'h010; req = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      @(posedge clk); #1;
      r = (c >= 15) ? c - 15 : c;
      check($sformatf("t1 cmd c%0d", c), 16'({nras, ncas, nwe}), 16'(exp_cmd(r, 4, 11)));
      check($sformatf("t1 busy c%0d", c), 16'(busy), 16'(r >= 1 && r <= 14));
      check($sformatf("t1 exit c%0d", c), 16'(ext), 16'(r == 14));
      check($sformatf("t1 vld c%0d", c), 16'(vld), 16'(r >= 8 && r <= 11));
      check($sformatf("t1 BA c%0d", c), 16'(ba), (c >= 15) ? 16'd1 : 16'd2);
      check($sformatf("t1 pins c%0d", c), 16'({cke, ncs, dqm}), 16'h0008);
      if (r == 1) check($sformatf("t1 act A c%0d", c), 16'(a), (c >= 15) ? 16'h1234 : 16'h0ABC);
      if (r == 4) check($sformatf("t1 rd A c%0d", c), 16'(a), (c >= 15) ? 16'h01FF : 16'h0010);
      if (r == 11) check($sformatf("t1 pre A c%0d", c), 16'(a), 16'h0000);
      if (r >= 8 && r <= 11)
        check($sformatf("t1 data c%0d", c), data, (c >= 15) ? wb[r-8] : wa[r-8]);
      dq = (r >= 7 && r <= 10) ? ((c >= 15) ? wb[r-7] : wa[r-7]) : 16'hDEAD;
      case (c)
        0:  req = 1'b0;
        5:  begin req = 1'b1; bank = 2'd3; row = 13'h1FFF; col = 9'h1AA; end
        6:  req = 1'b0;
        13: begin req = 1'b1; bank = 2'd3; row = 13'h1FFF; col = 9'h1AA; end
        14: begin req = 1'b1; bank = 2'd1; row = 13'h1234; col = 9'h1FF; end
        15: req = 1'b0;
        default: ;
      endcase
    end

    // CL=2 / BL=8 build
    bank = 2'd3; row = 13'h0F0F; col = 9'h0AA; req2 = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      @(posedge clk); #1;
      if (c == 0) req2 = 1'b0;
      check($sformatf("t2 cmd c%0d", c), 16'({nras2, ncas2, nwe2}), 16'(exp_cmd(c, 4, 14)));
      check($sformatf("t2 busy c%0d", c), 16'(busy2), 16'(c >= 1 && c <= 17));
      check($sformatf("t2 exit c%0d", c), 16'(ext2), 16'(c == 17));
      check($sformatf("t2 vld c%0d", c), 16'(vld2), 16'(c >= 7 && c <= 14));
      check($sformatf("t2 pins c%0d", c), 16'({cke2, ncs2, dqm2}), 16'h0008);
      if (c == 1) check("t2 act A", 16'(a2), 16'h0F0F);
      if (c == 4) check("t2 rd A", 16'(a2), 16'h00AA);
      if (c >= 7 && c <= 14) check($sformatf("t2 data c%0d", c), data2, 16'h0100 + 16'(c - 7));
      dq = (c >= 6 && c <= 13) ? 16'h0100 + 16'(c - 6) : 16'hDEAD;
    end

    // Reset mid-burst
    bank = 2'd1; row = 13'h0222; col = 9'h033; req = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 0) req = 1'b0;
      dq = (c >= 7 && c <= 10) ? 16'hBAD0 + 16'(c - 7) : 16'hDEAD;
    end
    check("t4 pre-reset vld", 16'(vld), 16'h0001);
    check("t4 pre-reset data", data, 16'hBAD1);
    rst_n = 1'b0;
    #1;
    check("t4 rst cmd", 16'({nras, ncas, nwe}), 16'(NOP));
    check("t4 rst vld", 16'(vld), 16'h0000);
    check("t4 rst busy", 16'(busy), 16'h0000);
    check("t4 rst data", data, 16'h0000);
    check("t4 rst A/BA", 16'({a, ba}), 16'h0000);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("t4 idle c%0d", c), 16'({vld, busy, ext, nras, ncas, nwe}), 16'h0007);
    end
    check("t4 no stale data", data, 16'h0000);
    #1;
    txn_default(2'd0, 13'h1555, 9'h0C3, 16'h5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdr_rd.md
# sdr_rd

SDRAM single-burst read controller, the read-direction counterpart of the write controller in the SDRAM access path. On a one-cycle request it opens a row (ACTIVE), issues READ, waits CAS latency, and captures a fixed-length burst from the DQ bus. It then closes the bank (PRECHARGE) and pulses `rd_exit`. It drives the same SDRAM command/address pins as the write controller; the top-level arbiter muxes them.

## Interface
- `NRCD`, 3: ACTIVE-to-READ spacing in clocks (tRCD/tCK, from shared parameters).
- `NRP`, 3: PRECHARGE-to-exit spacing in clocks (tRP/tCK).
- `CL`, 3: CAS latency in clocks; legal 2 or 3.
- `BL`, 4: burst length in words; legal 1, 2, 4, 8; must match the mode register.
- `clk` in 1: controller clock (167 MHz); one clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `sdr_rd_req` in 1: one-cycle read request; honoured only in IDLE.
- `sdr_bank_addr` in 2: bank, latched on acceptance.
- `sdr_row_addr` in 13: row, latched on acceptance.
- `sdr_col_addr` in 9: start column, latched on acceptance.
- `sdr_CKE` out 1: tied 1.
- `sdr_nCS` out 1: tied 0.
- `sdr_BA` out 2: bank address.
- `sdr_A` out 13: row, column, or precharge address.
- `sdr_nRAS`, `sdr_nCAS`, `sdr_nWE` out 1 each: command.
- `sdr_DQM` out 2: tied 2'b00 (no read masking).
- `sdr_DQ` in 16: SDRAM read data; this block never drives DQ.
- `rd_data` out 16: captured read word.
- `rd_data_vld` out 1: `rd_data` valid this cycle.
- `rd_busy` out 1: high from acceptance through the `rd_exit` cycle.
- `rd_exit` out 1: one-cycle pulse when the precharge wait completes.

## Operation
- States: IDLE, ACTIVE, READ, BURST, PRECHARGE. Encoding is 4-bit.
- IDLE → ACTIVE when `sdr_rd_req` is sampled high. Address inputs are latched on the same edge. `rd_busy` rises.
- ACTIVE → READ after `NRCD` cycles.
- READ → BURST after one cycle.
- BURST → PRECHARGE after `CL`+`BL`−1 cycles, i.e. once the last data word is on DQ.
- PRECHARGE → IDLE after `NRP` cycles. `rd_exit` pulses in that final cycle.
- All commands are registered from the state transition and last exactly one cycle. NOP (111) is driven otherwise.
- Command encodings: ACTIVE 011, READ 101, PRECHARGE 010.
- `sdr_A` contents by command:
  - ACTIVE: the row.
  - READ: {A12:A11=0, A10=0 (no auto-precharge), A9=0, col}.
  - PRECHARGE: A10=0, single bank.
- `sdr_BA` holds the latched bank from acceptance until the next acceptance.
- Capture: a valid tag enters a `CL`-deep shift pipeline for each of `BL` cycles starting at the READ command cycle. When the tag emerges, `sdr_DQ` is registered into `rd_data` and `rd_data_vld` is set on the next edge.
- Requests arriving while `rd_busy`=1, including in the `rd_exit` cycle, are ignored and not queued.
- Reset (asynchronous, any time, including mid-burst):
  - State returns to IDLE.
  - The capture pipeline is cleared.
  - Command returns to NOP; `sdr_A`=0; `sdr_BA`=0.
  - `rd_data`=0; `rd_data_vld`=0; `rd_busy`=0; `rd_exit`=0.
  - There is no partial-burst reporting.

## Timing
- Defaults are used below. The request is sampled at edge 0; cycle n is the cycle after edge n.
- ACTIVE command in cycle 1; READ in cycle 1+`NRCD`=4.
- DQ words in cycles 4+`CL` to 4+`CL`+`BL`−1, i.e. 7–10.
- `rd_data_vld` high in cycles 8–11, contiguous. Latency from the READ command to the first valid word is `CL`+1.
- PRECHARGE in cycle 11; `rd_exit` in cycle 11+`NRP`=14.
- `rd_busy` is high in cycles 1–14. The earliest next acceptance is edge 15.
- Total request-to-exit is 1+`NRCD`+`CL`+`BL`+`NRP`=14 cycles.
- The BURST-state counter is 4 bits. It is never compared beyond `CL`+`BL`−1 ≤ 10.

## Structure
- Shared items live in the `sdr_parameters` include, already used by the write controller:
  - tCK, tRCD, tRP;
  - command encodings CMD_NOP/ACTIVE/READ/WRITE/PRECHARGE;
  - the register delay macro.
- One natural sub-module: `sdr_rd_capture`. It holds the `CL`-deep valid shift pipeline plus the DQ capture register, and outputs `rd_data`/`rd_data_vld`.
- The state machine, counter, and command/address registers stay in `sdr_rd`.

## Test plan
- Single read: request with bank 2, row 0x0ABC, col 0x010; model returns 0x1111, 0x2222, 0x3333, 0x4444.
  - Expect ACTIVE cycle 1 (A=0x0ABC, BA=2), READ cycle 4 (A=0x0010), PRECHARGE cycle 11.
  - Expect `rd_data_vld` cycles 8–11 with those four words in order, and `rd_exit` cycle 14.
- Request while busy: second request in cycle 6 and another in cycle 14.
  - Expect neither to produce a command; only the first transaction completes.
- Back-to-back: a new request at edge 15.
  - Expect ACTIVE in cycle 16 and identical spacing to the first transaction.
- `CL`=2, `BL`=8 build:
  - Expect READ cycle 4, `rd_data_vld` cycles 7–14, PRECHARGE cycle 14, `rd_exit` cycle 17.
- Reset mid-burst: assert `rst_n`=0 in cycle 9.
  - Expect immediate NOP, `rd_data_vld`=0, `rd_busy`=0.
  - After release, a new request yields a clean 14-cycle transaction with no stale data.
- DQ isolation:
  - Expect no transaction to drive `sdr_DQ`, and `sdr_DQM`=0, `sdr_CKE`=1, `sdr_nCS`=0 throughout.
